pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 28 ++
 rtl/pc_ras.sv | 72 +++++++
 rtl/pc_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// ============================================================================
// Module   : pc_gen_pkg
// Brief    : Shared types and constants for the PC generator slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        EXC  = 3'd0,
        BR   = 3'd1,
        RAS  = 3'd2,
        SEQ  = 3'd3,
        HOLD = 3'd4
    } npc_sel_e;

    localparam int PC_INC = 4;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module   : pc_ras
// Brief    : Circular return-address stack; push+pop together replaces the top.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_ras #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] top_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] top_idx;
    logic [PW-1:0] wr_idx;
    logic          wr_en;

    assign top_idx = ptr_q - PW'(1);
    assign top_o   = mem_q[top_idx];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));

    // A push into a full stack lands on the oldest slot because the pointer wraps.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push_i && pop_i && !empty_o) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push_i) begin
            wr_en  = 1'b1;
            ptr_d  = ptr_q + PW'(1);
            cnt_d  = full_o ? cnt_q : cnt_q + (PW+1)'(1);
        end else if (pop_i && !empty_o) begin
            ptr_d  = top_idx;
            cnt_d  = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch PC generator with exception/branch redirect and halt.
//            Define PC_GEN_RAS_EN to add the return-address stack.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_VEC = AW'(32'h0000_2FF4),
    parameter int            RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_ready_i,
    input  logic          halt_i,
    input  logic          exc_valid_i,
    input  logic [AW-1:0] exc_vec_i,
    input  logic          br_valid_i,
    input  logic [AW-1:0] br_target_i,
    input  logic          call_i,
    input  logic          ret_i,
    output logic [AW-1:0] pc_o,
    output logic          pc_valid_o,
    output logic          misalign_o
);
    pc_state_e     state_q, state_d;
    npc_sel_e      sel;
    logic [AW-1:0] pc_q, pc_d;
    logic          misalign_q, misalign_d;
    logic          fire;
    logic          redirect;
    logic [AW-1:0] ras_top;
    logic          ras_empty;
    logic          ras_push;
    logic          ras_pop;

    assign fire     = pc_valid_o & fetch_ready_i;
    assign redirect = (state_q != BOOT) & (exc_valid_i | br_valid_i);

`ifdef PC_GEN_RAS_EN
    logic ras_full;
    logic ras_unused;

    assign ras_push   = fire & ~redirect & call_i;
    assign ras_pop    = fire & ~redirect & ret_i & ~ras_empty;
    assign ras_unused = ras_full;

    pc_ras #(
        .DW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (pc_q + AW'(PC_INC)),
        .top_o   (ras_top),
        .empty_o (ras_empty),
        .full_o  (ras_full)
    );
`else
    logic ras_unused;

    assign ras_push   = 1'b0;
    assign ras_pop    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_unused = ^{call_i, ret_i, ras_push, ras_top, ras_empty};
`endif

    always_comb begin
        sel = HOLD;
        if (state_q != BOOT) begin
            if (exc_valid_i)     sel = EXC;
            else if (br_valid_i) sel = BR;
            else if (ras_pop)    sel = RAS;
            else if (fire)       sel = SEQ;
        end
    end

    // Only exception/branch targets can be misaligned; RAS entries are pc+4.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        case (sel)
            EXC: begin
                pc_d       = {exc_vec_i[AW-1:2], 2'b00};
                misalign_d = |exc_vec_i[1:0];
            end
            BR: begin
                pc_d       = {br_target_i[AW-1:2], 2'b00};
                misalign_d = |br_target_i[1:0];
            end
            RAS:     pc_d = ras_top;
            SEQ:     pc_d = pc_q + AW'(PC_INC);
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = halt_i ? HALT : RUN;
            HALT:    state_d = (redirect && !halt_i) ? RUN : HALT;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_valid_o = (state_q == RUN);
        pc_o       = pc_q;
        misalign_o = misalign_q;
    end

endmodule

`default_nettype wire
